// File: rtl/dbi_rx_decoder.sv
`default_nettype none
// ============================================================================
// dbi_rx_decoder : MIPI DBI Type-B write-bus receiver, byte decoder + FIFO
// Revision 1.0
// ============================================================================
module dbi_rx_decoder #(
  parameter int DBI_IF_D_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbi_csx_i,
  input  logic                  dbi_dcx_i,
  input  logic                  dbi_wrx_i,
  input  logic                  dbi_rdx_i,
  input  logic                  dbi_resx_i,
  input  logic [DBI_IF_D_W-1:0] dbi_d_i,
  output logic [DBI_IF_D_W-1:0] rx_data_o,
  output logic                  rx_dcx_o,
  output logic [IDX_W-1:0]      rx_idx_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DBI_IF_D_W-1:0] last_cmd_o,
  output logic                  ovf_o,
  output logic                  rd_seen_o,
  input  logic                  err_clr_i,
  output logic                  disp_rst_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = IDX_W + 1 + DBI_IF_D_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX   = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SELECT = 2'd2
  } state_t;

  logic                  s1_csx, s2_csx;
  logic                  s1_dcx, s2_dcx;
  logic                  s1_wrx, s2_wrx, s3_wrx;
  logic                  s1_rdx, s2_rdx;
  logic                  s1_resx, s2_resx;
  logic [DBI_IF_D_W-1:0] s1_d, s2_d;

  // RESX stages reset low so the display is reported as held in reset while
  // rst_n is asserted; the other strobes reset to their idle-high level so a
  // fresh WRX low->high is needed before the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_csx  <= 1'b1;
      s2_csx  <= 1'b1;
      s1_dcx  <= 1'b1;
      s2_dcx  <= 1'b1;
      s1_wrx  <= 1'b1;
      s2_wrx  <= 1'b1;
      s3_wrx  <= 1'b1;
      s1_rdx  <= 1'b1;
      s2_rdx  <= 1'b1;
      s1_resx <= 1'b0;
      s2_resx <= 1'b0;
      s1_d    <= '0;
      s2_d    <= '0;
    end else begin
      s1_csx  <= dbi_csx_i;
      s2_csx  <= s1_csx;
      s1_dcx  <= dbi_dcx_i;
      s2_dcx  <= s1_dcx;
      s1_wrx  <= dbi_wrx_i;
      s2_wrx  <= s1_wrx;
      s3_wrx  <= s2_wrx;
      s1_rdx  <= dbi_rdx_i;
      s2_rdx  <= s1_rdx;
      s1_resx <= dbi_resx_i;
      s2_resx <= s1_resx;
      s1_d    <= dbi_d_i;
      s2_d    <= s1_d;
    end
  end

  state_t state, state_nxt;
  logic   capture, rd_set, enter_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Decisions follow the synchronized pins directly so a capture lands
  // exactly two edges after the WRX rise is first sampled.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    rd_set      = 1'b0;
    enter_reset = 1'b0;
    if (!s2_resx) begin
      state_nxt = ST_RESET;
    end else if (s2_csx) begin
      state_nxt = ST_IDLE;
    end else begin
      state_nxt = ST_SELECT;
    end
    enter_reset = (state_nxt == ST_RESET) && (state != ST_RESET);
    if (state_nxt == ST_SELECT) begin
      capture = s2_wrx && !s3_wrx;
      rd_set  = !s2_rdx;
    end
  end

  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] entry_idx;

  assign entry_idx = s2_dcx ? idx_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_cnt    <= IDX_FIRST;
      last_cmd_o <= '0;
    end else if (enter_reset) begin
      idx_cnt    <= IDX_FIRST;
      last_cmd_o <= '0;
    end else if (capture) begin
      if (!s2_dcx) begin
        idx_cnt    <= IDX_FIRST;
        last_cmd_o <= s2_d;
      end else if (idx_cnt != IDX_MAX) begin
        idx_cnt <= idx_cnt + 1'b1;
      end
    end
  end

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, push, pop, drop;
  logic [IDX_W-1:0]      head_idx;
  logic                  head_dcx;
  logic [DBI_IF_D_W-1:0] head_data;

  // Fullness is judged on the current count, so a same-cycle pop never
  // makes room for the incoming byte.
  assign full = (count == DEPTH_CNT);
  assign push = capture && !full;
  assign drop = capture && full;
  assign pop  = rx_valid_o && rx_ready_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {entry_idx, s2_dcx, s2_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (enter_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {head_idx, head_dcx, head_data} = mem[rd_ptr];

  assign rx_valid_o = (count != '0);
  assign rx_data_o  = rx_valid_o ? head_data : '0;
  assign rx_dcx_o   = rx_valid_o ? head_dcx  : 1'b0;
  assign rx_idx_o   = rx_valid_o ? head_idx  : '0;

  // Sticky flags: a set event in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o     <= 1'b0;
      rd_seen_o <= 1'b0;
    end else begin
      if (drop) begin
        ovf_o <= 1'b1;
      end else if (err_clr_i) begin
        ovf_o <= 1'b0;
      end
      if (rd_set) begin
        rd_seen_o <= 1'b1;
      end else if (err_clr_i) begin
        rd_seen_o <= 1'b0;
      end
    end
  end

  assign disp_rst_o = ~s2_resx;

endmodule
`default_nettype wire

// File: tb/tb_dbi_rx_decoder.sv
`default_nettype none
// Bench for dbi_rx_decoder: directed vector table, hand sequences for
// multi-cycle corners, and a randomized run against a transaction-level model.
module tb_dbi_rx_decoder;

  logic       clk;
  logic       rst_n;
  logic       dbi_csx, dbi_dcx, dbi_wrx, dbi_rdx, dbi_resx;
  logic [7:0] dbi_d;
  logic [7:0] rx_data;
  logic       rx_dcx;
  logic [7:0] rx_idx;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] last_cmd;
  logic       ovf, rd_seen, err_clr, disp_rst;

  logic [1:0] ready_mode;
  logic       rnd_ready;
  logic       mon_en;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {
    logic [7:0] idx;
    logic       dcx;
    logic [7:0] data;
  } entry_t;

  typedef struct {
    logic       dc;
    logic [7:0] d;
    logic       gap;
    logic [7:0] e_idx;
    logic [7:0] e_last;
  } vec_t;

  entry_t     exp_q[$];
  int         m_idx;
  logic [7:0] m_last;
  vec_t       vec[9];
  logic       rc, rdc;
  logic [7:0] rb;
  int         hi, n;
  logic [7:0] lst;

  dbi_rx_decoder #(.DBI_IF_D_W(8), .FIFO_DEPTH(16), .IDX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbi_csx_i  (dbi_csx),
    .dbi_dcx_i  (dbi_dcx),
    .dbi_wrx_i  (dbi_wrx),
    .dbi_rdx_i  (dbi_rdx),
    .dbi_resx_i (dbi_resx),
    .dbi_d_i    (dbi_d),
    .rx_data_o  (rx_data),
    .rx_dcx_o   (rx_dcx),
    .rx_idx_o   (rx_idx),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .last_cmd_o (last_cmd),
    .ovf_o      (ovf),
    .rd_seen_o  (rd_seen),
    .err_clr_i  (err_clr),
    .disp_rst_o (disp_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(3) != 0);
  end

  assign rx_ready = (ready_mode == 2'd2) ? rnd_ready : ready_mode[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus write: data/DCX set up with WRX low for 3 clk, WRX high for 3 clk.
  task automatic wr_byte(input logic dc, input logic [7:0] b);
    @(posedge clk);
    #1 dbi_dcx = dc;
    dbi_d   = b;
    dbi_wrx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_wrx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop_one;
    @(posedge clk);
    #1 ready_mode = 2'd1;
    @(posedge clk);
    #1 ready_mode = 2'd0;
    @(negedge clk);
  endtask

  task automatic pulse_clr;
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level model: what a display would record for a bus write.
  task automatic model_write(input logic cs_low, input logic dc, input logic [7:0] b);
    if (cs_low) begin
      if (!dc) begin
        exp_q.push_back({8'd0, 1'b0, b});
        m_last = b;
        m_idx  = 1;
      end else begin
        exp_q.push_back({8'(m_idx), 1'b1, b});
        if (m_idx < 255) m_idx++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rand_unexpected: got entry 0x%0h with none expected", {rx_idx, rx_dcx, rx_data});
      end else begin
        check("rand_entry", {rx_idx, rx_dcx, rx_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{1'b1, 8'h11, 1'b0, 8'd1, 8'h2C};
    vec[1] = '{1'b1, 8'h22, 1'b0, 8'd2, 8'h2C};
    vec[2] = '{1'b1, 8'h33, 1'b0, 8'd3, 8'h2C};
    vec[3] = '{1'b0, 8'h3A, 1'b0, 8'd0, 8'h3A};
    vec[4] = '{1'b1, 8'h55, 1'b1, 8'd1, 8'h3A};
    vec[5] = '{1'b1, 8'h66, 1'b0, 8'd2, 8'h3A};
    vec[6] = '{1'b0, 8'h29, 1'b1, 8'd0, 8'h29};
    vec[7] = '{1'b1, 8'h01, 1'b1, 8'd1, 8'h29};
    vec[8] = '{1'b1, 8'h02, 1'b0, 8'd2, 8'h29};

    rst_n = 1'b0;
    dbi_csx = 1'b1; dbi_dcx = 1'b1; dbi_wrx = 1'b1; dbi_rdx = 1'b1;
    dbi_resx = 1'b1; dbi_d = 8'h00; err_clr = 1'b0;
    ready_mode = 2'd0; mon_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_dcx", rx_dcx, 0);
    check("rst_idx", rx_idx, 0);
    check("rst_last_cmd", last_cmd, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd_seen", rd_seen, 0);
    check("rst_disp_rst", disp_rst, 1);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("disp_rst_release", disp_rst, 0);

    // First-capture latency: valid appears 3 edges after the WRX rise
    dbi_csx = 1'b0;
    @(posedge clk);
    #1 dbi_dcx = 1'b0; dbi_d = 8'h2C; dbi_wrx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_wrx = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("lat_valid", rx_valid, (i == 3));
    end
    check("lat_entry", {rx_idx, rx_dcx, rx_data}, {8'd0, 1'b0, 8'h2C});
    check("lat_last_cmd", last_cmd, 8'h2C);
    pop_one();
    check("lat_pop_empty", rx_valid, 0);

    // Table-driven vectors, including commands spread over CSX frames
    for (int i = 0; i < 9; i++) begin
      if (vec[i].gap) begin
        dbi_csx = 1'b1;
        repeat (3) @(posedge clk);
        #1 dbi_csx = 1'b0;
      end
      wr_byte(vec[i].dc, vec[i].d);
      @(negedge clk);
      check("vec_valid", rx_valid, 1);
      check("vec_data", rx_data, vec[i].d);
      check("vec_dcx", rx_dcx, vec[i].dc);
      check("vec_idx", rx_idx, vec[i].e_idx);
      check("vec_last_cmd", last_cmd, vec[i].e_last);
      pop_one();
      check("vec_pop_empty", rx_valid, 0);
    end

    // Overflow: command + 17 data bytes into a 16-deep FIFO
    wr_byte(1'b0, 8'hA0);
    for (int i = 1; i <= 17; i++) wr_byte(1'b1, 8'(i));
    @(negedge clk);
    check("ovf_set", ovf, 1);
    check("ovf_last_cmd", last_cmd, 8'hA0);
    ready_mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", {rx_valid, rx_idx}, {1'b1, 8'(i)});
      @(negedge clk);
    end
    ready_mode = 2'd0;
    check("ovf_drained", rx_valid, 0);
    wr_byte(1'b1, 8'hEE);
    @(negedge clk);
    check("ovf_idx_after_drop", rx_idx, 18);
    pop_one();
    pulse_clr();
    check("ovf_cleared", ovf, 0);

    // Full FIFO with a pop on the very edge the next byte would be written
    for (int i = 0; i < 16; i++) wr_byte(1'b1, 8'h40 + 8'(i));
    @(negedge clk);
    check("full_no_ovf", ovf, 0);
    @(posedge clk);
    #1 dbi_dcx = 1'b1; dbi_d = 8'h99; dbi_wrx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_wrx = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 ready_mode = 2'd1;
    @(posedge clk);
    #1 ready_mode = 2'd0;
    @(negedge clk);
    check("full_pop_ovf", ovf, 1);
    ready_mode = 2'd1;
    n = 0;
    lst = 8'h00;
    for (int t = 0; t < 40; t++) begin
      if (!rx_valid) break;
      n++;
      lst = rx_idx;
      @(negedge clk);
    end
    ready_mode = 2'd0;
    check("full_pop_count", n, 15);
    check("full_pop_last_idx", lst, 34);
    pulse_clr();

    // CSX high: writes and reads ignored; RDX with CSX low is flagged
    dbi_csx = 1'b1;
    wr_byte(1'b0, 8'h77);
    wr_byte(1'b1, 8'h78);
    @(posedge clk);
    #1 dbi_rdx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_rdx = 1'b1;
    @(negedge clk);
    check("csx_hi_no_entry", rx_valid, 0);
    check("csx_hi_no_rd", rd_seen, 0);
    check("csx_hi_last_cmd", last_cmd, 8'hA0);
    dbi_csx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_rdx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rd_seen_set", rd_seen, 1);
    pulse_clr();
    check("rd_seen_set_wins", rd_seen, 1);
    dbi_rdx = 1'b1;
    repeat (3) @(posedge clk);
    pulse_clr();
    check("rd_seen_cleared", rd_seen, 0);
    check("rd_no_entry", rx_valid, 0);

    // RESX pulse flushes 5 pending entries
    wr_byte(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) wr_byte(1'b1, 8'hC0 + 8'(i));
    @(posedge clk);
    #1 dbi_resx = 1'b0;
    hi = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      if (i == 4) #1 dbi_resx = 1'b1;
      @(negedge clk);
      if (disp_rst) hi++;
      if (i == 1) check("resx_disp_lag", disp_rst, 0);
      if (i == 2) check("resx_pre_flush", rx_valid, 1);
      if (i == 3) check("resx_flushed", rx_valid, 0);
      if (i == 3) check("resx_last_cmd", last_cmd, 0);
    end
    check("resx_disp_width", hi, 4);
    wr_byte(1'b1, 8'h5A);
    @(negedge clk);
    check("resx_next_entry", {rx_idx, rx_dcx, rx_data}, {8'd1, 1'b1, 8'h5A});
    pop_one();

    // rst_n asserted mid-burst
    @(posedge clk);
    #1 dbi_rdx = 1'b0;
    repeat (3) @(posedge clk);
    #1 dbi_rdx = 1'b1;
    wr_byte(1'b0, 8'h2C);
    wr_byte(1'b1, 8'h01);
    @(negedge clk);
    check("pre_rst_rd_seen", rd_seen, 1);
    check("pre_rst_valid", rx_valid, 1);
    @(posedge clk);
    #1 dbi_d = 8'h02; dbi_wrx = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_head", {rx_idx, rx_dcx, rx_data}, 0);
    check("mid_rst_last_cmd", last_cmd, 0);
    check("mid_rst_flags", {ovf, rd_seen}, 0);
    check("mid_rst_disp_rst", disp_rst, 1);
    dbi_wrx = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_capture", rx_valid, 0);
    wr_byte(1'b0, 8'h29);
    @(negedge clk);
    check("post_rst_entry", {rx_valid, rx_idx, rx_dcx, rx_data}, {1'b1, 8'd0, 1'b0, 8'h29});
    check("post_rst_last_cmd", last_cmd, 8'h29);
    pop_one();

    // Randomized traffic with random back-pressure against the model
    m_idx = 1;
    m_last = 8'h29;
    ready_mode = 2'd2;
    mon_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rc  = ($urandom_range(7) != 0);
      rdc = ($urandom_range(3) != 0);
      rb  = 8'($urandom);
      model_write(rc, rdc, rb);
      dbi_csx = !rc;
      wr_byte(rdc, rb);
    end
    dbi_csx = 1'b0;
    for (int i = 0; i < 260; i++) begin
      rb = 8'($urandom);
      model_write(1'b1, 1'b1, rb);
      wr_byte(1'b1, rb);
    end
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("rand_drained", exp_q.size(), 0);
    @(negedge clk);
    mon_en = 1'b0;
    check("rand_valid_end", rx_valid, 0);
    check("rand_last_cmd", last_cmd, m_last);
    check("rand_no_ovf", ovf, 0);
    check("rand_idx_sat", m_idx, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
